div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 27 ++
 rtl/div_unit.sv | 160 ++++++++++++++++
 tb/tb_div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide/remainder unit: operation
// encodings (funct3[1:0]), the control state type and a small op decoder.
package div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    // DIV and REM are the signed forms; bit 0 of the encoding marks unsigned.
    function automatic logic is_signed_op(input logic [1:0] op_code);
        return ~op_code[0];
    endfunction

    // Bit 1 of the encoding selects the remainder rather than the quotient.
    function automatic logic is_rem_op(input logic [1:0] op_code);
        return op_code[1];
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. One quotient bit per
// cycle in CALC, sign correction and result select in FIX, a one-cycle done
// pulse in DONE. Divide-by-zero and signed overflow bypass the iteration.
module div_unit
    import div_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 kill,
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] result
);

    localparam int CNT_W = $clog2(WORD_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_SIZE - 1);
    localparam logic [WORD_SIZE-1:0] MIN_INT = {1'b1, {(WORD_SIZE-1){1'b0}}};

    div_state_t state_reg, state_next;

    logic                 sel_rem_reg;
    logic                 qsign_reg;
    logic                 rsign_reg;
    logic [WORD_SIZE-1:0] quo_reg;
    logic [WORD_SIZE-1:0] rem_reg;
    logic [WORD_SIZE-1:0] divisor_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WORD_SIZE-1:0] result_reg;

    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WORD_SIZE-1:0] neg0_in;
    logic [WORD_SIZE-1:0] neg1_in;
    logic [WORD_SIZE-1:0] neg0_out;
    logic [WORD_SIZE-1:0] neg1_out;
    logic [WORD_SIZE-1:0] a_mag;
    logic [WORD_SIZE-1:0] b_mag;
    logic                 div_by_zero;
    logic                 overflow;
    logic                 special;
    logic [WORD_SIZE-1:0] special_result;
    logic                 accept;
    logic [WORD_SIZE:0]   rem_shift;
    logic [WORD_SIZE:0]   trial;
    logic                 take;
    logic [WORD_SIZE-1:0] quo_fix;
    logic [WORD_SIZE-1:0] rem_fix;

    // Operand decode, the two shared negators and the trial subtractor.
    // The negators take the raw operands while idle (magnitudes) and the
    // quotient/remainder in FIX (sign correction), so only two are needed.
    always_comb begin
        op_signed      = is_signed_op(op);
        a_neg          = op_signed & a[WORD_SIZE-1];
        b_neg          = op_signed & b[WORD_SIZE-1];
        neg0_in        = (state_reg == ST_FIX) ? quo_reg : a;
        neg1_in        = (state_reg == ST_FIX) ? rem_reg : b;
        neg0_out       = '0 - neg0_in;
        neg1_out       = '0 - neg1_in;
        a_mag          = a_neg ? neg0_out : a;
        b_mag          = b_neg ? neg1_out : b;
        div_by_zero    = (b == '0);
        overflow       = op_signed && (a == MIN_INT) && (b == '1);
        special        = div_by_zero | overflow;
        special_result = '0;
        if (div_by_zero) begin
            special_result = is_rem_op(op) ? a : '1;
        end else if (overflow) begin
            special_result = is_rem_op(op) ? '0 : MIN_INT;
        end
        rem_shift      = {rem_reg, quo_reg[WORD_SIZE-1]};
        trial          = rem_shift - {1'b0, divisor_reg};
        take           = ~trial[WORD_SIZE];
        quo_fix        = qsign_reg ? neg0_out : quo_reg;
        rem_fix        = rsign_reg ? neg1_out : rem_reg;
    end

    // Control: next state, busy/done and the operation-accept strobe.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                done = (state_reg == ST_DONE);
                if (start) begin
                    accept     = ~kill;
                    state_next = special ? ST_DONE : ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (cnt_reg == LAST_ITER) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (kill) begin
            state_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: operand latch, one restoring step per CALC cycle, result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_rem_reg <= 1'b0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            sel_rem_reg <= is_rem_op(op);
            qsign_reg   <= op_signed & (a[WORD_SIZE-1] ^ b[WORD_SIZE-1]);
            rsign_reg   <= op_signed & a[WORD_SIZE-1];
            quo_reg     <= a_mag;
            rem_reg     <= '0;
            divisor_reg <= b_mag;
            cnt_reg     <= '0;
            if (special) begin
                result_reg <= special_result;
            end
        end else if (!kill && state_reg == ST_CALC) begin
            quo_reg <= {quo_reg[WORD_SIZE-2:0], take};
            rem_reg <= take ? trial[WORD_SIZE-1:0] : rem_shift[WORD_SIZE-1:0];
            cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (!kill && state_reg == ST_FIX) begin
            result_reg <= sel_rem_reg ? rem_fix : quo_fix;
        end
    end

    assign result = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: normal signed/unsigned ops with latency,
// special cases, back-to-back issue, start-while-busy, kill and reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.WORD_SIZE(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; issues one op and returns at the negedge of the
    // done cycle, so a further call issues back-to-back in the DONE cycle.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int n;
        logic busy_any;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        busy_any = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_any = 1'b1;
        end while (!done && n < 100);
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " busy seen"}, {31'd0, busy_any}, {31'd0, (exp_lat > 1)});
        $display("op=%0d a=%h b=%h result=%h cycles=%0d", o, x, y, result, n);
    endtask

    initial begin
        int  n;
        logic saw_done;
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal operations
        do_op("divu 100/7",  2'b01, 32'd100, 32'd7, 32'd14, 34);
        @(negedge clk);
        do_op("remu 100/7",  2'b11, 32'd100, 32'd7, 32'd2, 34);
        @(negedge clk);
        do_op("div -100/7",  2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);
        @(negedge clk);
        do_op("rem -100/7",  2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34);
        @(negedge clk);
        do_op("div 100/-7",  2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        @(negedge clk);
        do_op("rem 100/-7",  2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 34);
        @(negedge clk);
        do_op("divu max/16", 2'b01, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 34);
        @(negedge clk);
        do_op("remu max/16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 34);
        @(negedge clk);

        // Special cases
        do_op("div 5/0",     2'b00, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        @(negedge clk);
        do_op("remu 5/0",    2'b11, 32'd5, 32'd0, 32'd5, 1);
        @(negedge clk);
        do_op("div ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        @(negedge clk);
        do_op("rem ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        @(negedge clk);

        // Back-to-back: second start in the DONE cycle
        do_op("b2b first",   2'b01, 32'd100, 32'd7, 32'd14, 34);
        do_op("b2b second",  2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);
        do_op("b2b special", 2'b01, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
        @(negedge clk);

        // start while busy is ignored
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (5) begin @(negedge clk); n++; end
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(negedge clk); n++;
        start = 1'b0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("busy start latency", 32'(n), 32'd34);
        check("busy start result", result, 32'd14);
        $display("op=1 a=00000064 b=00000007 (restart ignored) result=%h cycles=%0d", result, n);
        @(negedge clk);

        // kill in cycle 10
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (10) begin @(negedge clk); n++; end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        saw_done = done;
        repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
        check("kill no done", {31'd0, saw_done}, 32'd0);
        check("kill result", result, 32'd14);
        $display("op=1 a=000003e8 b=0000000a killed result=%h", result);
        do_op("divu 9/3",    2'b01, 32'd9, 32'd3, 32'd3, 34);
        @(negedge clk);

        // reset in cycle 5
        start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin @(negedge clk); if (done) saw_done = 1'b1; end
        check("rst no done", {31'd0, saw_done}, 32'd0);
        $display("op=1 a=00000064 b=00000007 reset result=%h", result);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
